// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word fetches under a two-slot credit, queues responses
// in order with their PCs, and presents one instruction per cycle to instruction_control.
module instruction_fetch #(
    parameter int N = 24,
    parameter int A = 10,
    parameter int VBIT = 23,
    parameter logic [N-1:0] NOP = 24'h100004
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         branch_taken,
    input  logic [A-1:0] branch_target,
    output logic         imem_req,
    output logic [A-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] instruction,
    output logic         V,
    output logic [A-1:0] pc_out,
    output logic         inst_valid
);

    // imem handshake: a request transfers in any cycle where imem_req && imem_ready;
    // imem_addr is held until then. Responses return in request order on imem_rvalid.
    logic [A-1:0] pc;
    logic [1:0]   outstanding;   // issued but not yet returned, stale ones included
    logic [1:0]   count;         // entries waiting in the response queue
    logic [1:0]   stale;         // returning responses still to be discarded

    logic [A-1:0] tag_q [2];
    logic         tag_wr, tag_rd;
    logic [N-1:0] q_data [2];
    logic [A-1:0] q_pc [2];
    logic         q_wr, q_rd;

    logic redirect, credit, issue, resp, drop, push, pop;

    assign redirect  = flush | branch_taken;
    assign credit    = ({1'b0, outstanding} + {1'b0, count}) < 3'd2;
    assign imem_req  = ~rst & ~redirect & credit;
    assign imem_addr = pc;
    assign issue     = imem_req & imem_ready;
    // A response with nothing outstanding belongs to a request lost across reset.
    assign resp      = imem_rvalid & (outstanding != 2'd0);
    assign drop      = resp & (stale != 2'd0);
    assign push      = resp & ~drop & ~redirect;
    assign pop       = ~stall & (count != 2'd0) & ~redirect;
    assign V         = instruction[VBIT] & inst_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            outstanding <= 2'd0;
            count       <= 2'd0;
            stale       <= 2'd0;
            tag_wr      <= 1'b0;
            tag_rd      <= 1'b0;
            q_wr        <= 1'b0;
            q_rd        <= 1'b0;
            instruction <= NOP;
            pc_out      <= '0;
            inst_valid  <= 1'b0;
        end else begin
            outstanding <= outstanding + {1'b0, issue} - {1'b0, resp};
            if (issue)
                tag_wr <= ~tag_wr;
            if (resp)
                tag_rd <= ~tag_rd;

            if (branch_taken)
                pc <= branch_target;
            else if (issue)
                pc <= pc + A'(1);

            // Everything still in flight at a redirect is stale, including a response
            // that lands in the redirect cycle itself (that one is dropped right away).
            if (redirect)
                stale <= outstanding - {1'b0, resp};
            else if (drop)
                stale <= stale - 2'd1;

            if (redirect) begin
                count <= 2'd0;
                q_wr  <= 1'b0;
                q_rd  <= 1'b0;
            end else begin
                if (push)
                    q_wr <= ~q_wr;
                if (pop)
                    q_rd <= ~q_rd;
                count <= count + {1'b0, push} - {1'b0, pop};
            end

            if (redirect) begin
                instruction <= NOP;
                inst_valid  <= 1'b0;
            end else if (!stall) begin
                if (count != 2'd0) begin
                    instruction <= q_data[q_rd];
                    pc_out      <= q_pc[q_rd];
                    inst_valid  <= 1'b1;
                end else begin
                    instruction <= NOP;
                    inst_valid  <= 1'b0;
                end
            end
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (issue)
            tag_q[tag_wr] <= pc;
        if (push && !rst) begin
            q_data[q_wr] <= imem_rdata;
            q_pc[q_wr]   <= tag_q[tag_rd];
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a behavioural instruction memory with programmable
// latency, a per-cycle vector table for sequential fetch, and hand-built corner sequences.
module tb_instruction_fetch;

    localparam int N = 24;
    localparam int A = 10;
    localparam logic [N-1:0] NOP = 24'h100004;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         branch_taken = 1'b0;
    logic [A-1:0] branch_target = '0;
    logic         imem_req;
    logic [A-1:0] imem_addr;
    logic         imem_ready = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [N-1:0] imem_rdata = '0;
    logic [N-1:0] instruction;
    logic         V;
    logic [A-1:0] pc_out;
    logic         inst_valid;

    instruction_fetch #(.N(N), .A(A), .VBIT(23), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .V(V), .pc_out(pc_out), .inst_valid(inst_valid)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 1;
    logic [A-1:0] mem_addr_q[$];
    int           mem_due_q[$];
    logic [A-1:0] exp_q[$];

    logic         s_req, s_iv, s_v;
    logic [A-1:0] s_addr, s_pc;
    logic [N-1:0] s_ins;

    typedef struct {
        logic         rdy;
        logic         e_req;
        logic [A-1:0] e_addr;
        logic         e_iv;
        logic [A-1:0] e_pc;
    } vec_t;
    vec_t tbl[15];

    // Memory image: word a holds ((a+1)<<8) with bit 23 set for odd addresses.
    function automatic logic [N-1:0] mem_data(input logic [A-1:0] a);
        logic [22:0] lo;
        lo = 23'(({13'b0, a} + 23'd1) << 8);
        return {a[0], lo};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock cycle: drive inputs and the memory response, sample, then advance.
    task automatic step(input logic st, input logic fl, input logic br,
                        input logic [A-1:0] tgt, input logic rdy);
        stall = st;
        flush = fl;
        branch_taken = br;
        branch_target = tgt;
        imem_ready = rdy;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem_data(mem_addr_q[0]);
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = '0;
        end
        #1;
        s_req = imem_req;
        s_addr = imem_addr;
        s_iv = inst_valid;
        s_v = V;
        s_pc = pc_out;
        s_ins = instruction;
        if (imem_req && imem_ready) begin
            mem_addr_q.push_back(imem_addr);
            mem_due_q.push_back(cyc + lat);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_sb();
        logic [A-1:0] e;
        if (s_iv) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got valid pc_out 0x%0h, expected bubble (cycle %0d)", s_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", s_pc, e);
                check("sb_ins", s_ins, mem_data(e));
                check("sb_v", s_v, e[0]);
            end
        end else begin
            check("sb_bubble_ins", s_ins, NOP);
            check("sb_bubble_v", s_v, 0);
        end
    endtask

    task automatic run_expect(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step(0, 0, 0, '0, 1);
            check_sb();
            n++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d outputs missing, expected 0 after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Reset with a redirect asserted on the same edges; it must be ignored.
    task automatic do_reset(input int l);
        rst = 1'b1;
        lat = l;
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_q.delete();
        step(0, 0, 0, '0, 1);
        step(0, 1, 1, 10'h155, 1);
        check("rst_req", s_req, 0);
        check("rst_iv", s_iv, 0);
        check("rst_pc", s_pc, 0);
        check("rst_ins", s_ins, NOP);
        check("rst_v", s_v, 0);
        rst = 1'b0;
        cyc = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Sequential fetch, 1-cycle memory, with imem_ready low for 3 cycles at PC=5.
        tbl[0]  = '{1'b1, 1'b1, 10'd0, 1'b0, 10'd0};
        tbl[1]  = '{1'b1, 1'b1, 10'd1, 1'b0, 10'd0};
        tbl[2]  = '{1'b1, 1'b0, 10'd2, 1'b0, 10'd0};
        tbl[3]  = '{1'b1, 1'b1, 10'd2, 1'b1, 10'd0};
        tbl[4]  = '{1'b1, 1'b1, 10'd3, 1'b1, 10'd1};
        tbl[5]  = '{1'b1, 1'b0, 10'd4, 1'b0, 10'd0};
        tbl[6]  = '{1'b1, 1'b1, 10'd4, 1'b1, 10'd2};
        tbl[7]  = '{1'b0, 1'b1, 10'd5, 1'b1, 10'd3};
        tbl[8]  = '{1'b0, 1'b1, 10'd5, 1'b0, 10'd0};
        tbl[9]  = '{1'b0, 1'b1, 10'd5, 1'b1, 10'd4};
        tbl[10] = '{1'b1, 1'b1, 10'd5, 1'b0, 10'd0};
        tbl[11] = '{1'b1, 1'b1, 10'd6, 1'b0, 10'd0};
        tbl[12] = '{1'b1, 1'b0, 10'd7, 1'b0, 10'd0};
        tbl[13] = '{1'b1, 1'b1, 10'd7, 1'b1, 10'd5};
        tbl[14] = '{1'b1, 1'b1, 10'd8, 1'b1, 10'd6};

        @(negedge clk);

        do_reset(1);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, '0, tbl[i].rdy);
            check("tbl_req", s_req, tbl[i].e_req);
            check("tbl_addr", s_addr, tbl[i].e_addr);
            check("tbl_iv", s_iv, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                check("tbl_pc", s_pc, tbl[i].e_pc);
                check("tbl_ins", s_ins, mem_data(tbl[i].e_pc));
                check("tbl_v", s_v, tbl[i].e_pc[0]);
            end else begin
                check("tbl_bubble_ins", s_ins, NOP);
                check("tbl_bubble_v", s_v, 0);
            end
        end

        // Stall for 4 cycles with the queue filling: outputs frozen, no requests.
        do_reset(1);
        exp_q = '{10'd0};
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, '0, 1);
            check_sb();
        end
        step(1, 0, 0, '0, 1);
        check_sb();
        for (int i = 0; i < 4; i++) begin
            step((i < 3) ? 1'b1 : 1'b0, 0, 0, '0, 1);
            check("stall_req", s_req, 0);
            check("stall_iv", s_iv, 1);
            check("stall_pc", s_pc, 0);
            check("stall_ins", s_ins, mem_data(10'd0));
        end
        exp_q = '{10'd1, 10'd2, 10'd3};
        run_expect("stall_release", 20);

        // Branch to 0x3FF with two requests outstanding on a 2-cycle memory.
        do_reset(2);
        step(0, 0, 0, '0, 1);
        check_sb();
        step(0, 0, 0, '0, 1);
        check_sb();
        step(0, 0, 1, 10'h3FF, 1);
        check("br_req_redirect", s_req, 0);
        check("br_iv", s_iv, 0);
        step(0, 0, 0, '0, 1);
        check("br_req_target", s_req, 1);
        check("br_addr_target", s_addr, 10'h3FF);
        check_sb();
        exp_q = '{10'h3FF, 10'h000, 10'h001};
        run_expect("branch_wrap", 30);

        // Flush under stall while a response lands in the same cycle.
        do_reset(1);
        exp_q = '{10'd0, 10'd1};
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, '0, 1);
            check_sb();
        end
        step(1, 1, 0, '0, 1);
        check("flush_rvalid", imem_rvalid, 1);
        check_sb();
        step(0, 0, 0, '0, 1);
        check("flush_ins", s_ins, NOP);
        check("flush_iv", s_iv, 0);
        check("flush_v", s_v, 0);
        check("flush_req", s_req, 1);
        check("flush_addr", s_addr, 10'd3);
        exp_q = '{10'd3, 10'd4, 10'd5};
        run_expect("flush_resume", 20);

        // Reset with two requests in flight on a 3-cycle memory; both return afterwards.
        do_reset(3);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        rst = 1'b1;
        step(0, 0, 0, '0, 1);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, '0, (i < 2) ? 1'b0 : 1'b1);
            check("rst_mid_iv", s_iv, 0);
            if (i == 0) begin
                check("rst_mid_req", s_req, 1);
                check("rst_mid_addr", s_addr, 10'd0);
            end
        end
        exp_q = '{10'd0, 10'd1, 10'd2};
        run_expect("post_reset", 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
